// File: rtl/axi_protocol_monitor.sv
// Passive AXI4 monitor: burst/LAST, response and ordering checks, completion counters,
// a stall watchdog and an optional AW/AR trace FIFO (enabled by defining AXI_MON_TRACE_EN).
module axi_protocol_monitor #(
  parameter int ADDR_WIDTH        = 32,
  parameter int OUTSTANDING_DEPTH = 4,
  parameter int TIMEOUT_CYCLES    = 1024,
  parameter int TRACE_DEPTH       = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  awvalid,
  input  logic                  awready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [7:0]            awlen,
  input  logic                  wvalid,
  input  logic                  wready,
  input  logic                  wlast,
  input  logic                  bvalid,
  input  logic                  bready,
  input  logic                  arvalid,
  input  logic                  arready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [7:0]            arlen,
  input  logic                  rvalid,
  input  logic                  rready,
  input  logic                  rlast,
  input  logic                  err_clear,
  output logic [8:0]            err_status,
  output logic                  err_any,
  output logic [31:0]           rd_count,
  output logic [31:0]           wr_count,
  output logic [$clog2(OUTSTANDING_DEPTH):0] rd_outstanding,
  output logic [$clog2(OUTSTANDING_DEPTH):0] wr_outstanding,
  output logic                  trace_valid,
  output logic [ADDR_WIDTH+9:0] trace_data,
  input  logic                  trace_ready
);

  localparam int QP_W = $clog2(OUTSTANDING_DEPTH);
  localparam int QC_W = QP_W + 1;
  localparam int WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [QC_W-1:0] Q_FULL   = QC_W'(OUTSTANDING_DEPTH);
  localparam logic [QC_W-1:0] CNT_MAX  = '1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs;
  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign b_hs   = bvalid && bready;
  assign ar_hs  = arvalid && arready;
  assign r_hs   = rvalid && rready;
  assign any_hs = aw_hs || w_hs || b_hs || ar_hs || r_hs;

  logic [7:0]      rq_mem_q [OUTSTANDING_DEPTH];
  logic [7:0]      rq_mem_d [OUTSTANDING_DEPTH];
  logic [QP_W-1:0] rq_wp_q, rq_wp_d, rq_rp_q, rq_rp_d;
  logic [QC_W-1:0] rq_cnt_q, rq_cnt_d;
  logic [8:0]      rbeat_q, rbeat_d, rbeat_n;
  logic            r_len_end, rq_push, rq_pop;
  logic [31:0]     rd_cnt_q, rd_cnt_d;

  logic [7:0]      wq_mem_q [OUTSTANDING_DEPTH];
  logic [7:0]      wq_mem_d [OUTSTANDING_DEPTH];
  logic [QP_W-1:0] wq_wp_q, wq_wp_d, wq_rp_q, wq_rp_d;
  logic [QC_W-1:0] wq_cnt_q, wq_cnt_d;
  logic [8:0]      wbeat_q, wbeat_d, wbeat_n;
  logic            w_len_end, wq_push, wq_pop, b_ok;
  logic [QC_W-1:0] wr_out_q, wr_out_d;
  logic [31:0]     wr_cnt_q, wr_cnt_d;

  logic [WD_W-1:0] wd_q, wd_d;
  logic [8:0]      err_q, err_d;
  logic [8:0]      err_rd, err_wr, err_wd, err_tr;

  // Read side: length queue doubles as the outstanding-burst count.
  always_comb begin
    rq_mem_d  = rq_mem_q;
    rq_wp_d   = rq_wp_q;
    rq_rp_d   = rq_rp_q;
    rbeat_d   = rbeat_q;
    rd_cnt_d  = rd_cnt_q;
    err_rd    = '0;
    rq_push   = 1'b0;
    rq_pop    = 1'b0;
    rbeat_n   = rbeat_q + 9'd1;
    r_len_end = (rbeat_n == ({1'b0, rq_mem_q[rq_rp_q]} + 9'd1));
    if (ar_hs) begin
      if (rq_cnt_q == Q_FULL) begin
        err_rd[8] = 1'b1;
      end else begin
        rq_mem_d[rq_wp_q] = arlen;
        rq_wp_d           = rq_wp_q + QP_W'(1);
        rq_push           = 1'b1;
      end
    end
    if (r_hs) begin
      if (rq_cnt_q == '0) begin
        err_rd[2] = 1'b1;
      end else begin
        if (rlast && !r_len_end) err_rd[0] = 1'b1;
        if (r_len_end && !rlast) err_rd[1] = 1'b1;
        if (rlast || r_len_end) begin
          rq_pop  = 1'b1;
          rq_rp_d = rq_rp_q + QP_W'(1);
          rbeat_d = '0;
          if (rlast) rd_cnt_d = rd_cnt_q + 32'd1;
        end else begin
          rbeat_d = rbeat_n;
        end
      end
    end
    rq_cnt_d = rq_cnt_q + QC_W'(rq_push) - QC_W'(rq_pop);
  end

  // Write side: the queue tracks W bursts, wr_out tracks bursts still owed a B.
  always_comb begin
    wq_mem_d  = wq_mem_q;
    wq_wp_d   = wq_wp_q;
    wq_rp_d   = wq_rp_q;
    wbeat_d   = wbeat_q;
    wr_cnt_d  = wr_cnt_q;
    wr_out_d  = wr_out_q;
    err_wr    = '0;
    wq_push   = 1'b0;
    wq_pop    = 1'b0;
    b_ok      = 1'b0;
    wbeat_n   = wbeat_q + 9'd1;
    w_len_end = (wbeat_n == ({1'b0, wq_mem_q[wq_rp_q]} + 9'd1));
    if (aw_hs) begin
      if (wq_cnt_q == Q_FULL) begin
        err_wr[8] = 1'b1;
      end else begin
        wq_mem_d[wq_wp_q] = awlen;
        wq_wp_d           = wq_wp_q + QP_W'(1);
        wq_push           = 1'b1;
      end
    end
    if (w_hs) begin
      if (wq_cnt_q == '0) begin
        err_wr[4] = 1'b1;
      end else begin
        if (wlast != w_len_end) err_wr[3] = 1'b1;
        if (wlast || w_len_end) begin
          wq_pop  = 1'b1;
          wq_rp_d = wq_rp_q + QP_W'(1);
          wbeat_d = '0;
        end else begin
          wbeat_d = wbeat_n;
        end
      end
    end
    if (b_hs) begin
      if (wr_out_q == '0) err_wr[5] = 1'b1;
      else                b_ok      = 1'b1;
    end
    if (b_ok) wr_cnt_d = wr_cnt_q + 32'd1;
    if (wq_push && !b_ok && wr_out_q != CNT_MAX) wr_out_d = wr_out_q + QC_W'(1);
    else if (b_ok && !wq_push)                   wr_out_d = wr_out_q - QC_W'(1);
    wq_cnt_d = wq_cnt_q + QC_W'(wq_push) - QC_W'(wq_pop);
  end

  // Watchdog saturates at the limit; the error fires on the cycle after it gets there.
  always_comb begin
    wd_d   = '0;
    err_wd = '0;
    if (TIMEOUT_CYCLES != 0) begin
      if (!any_hs && (rq_cnt_q != '0 || wr_out_q != '0)) begin
        wd_d = (wd_q == WD_LIMIT) ? wd_q : wd_q + WD_W'(1);
      end
      if (wd_q == WD_LIMIT) err_wd[6] = 1'b1;
    end
  end

`ifdef AXI_MON_TRACE_EN
  localparam int TP_W = $clog2(TRACE_DEPTH);
  localparam int TC_W = TP_W + 1;
  localparam int TD_W = ADDR_WIDTH + 10;

  logic [TD_W-1:0] tf_mem_q [TRACE_DEPTH];
  logic [TD_W-1:0] tf_mem_d [TRACE_DEPTH];
  logic [TP_W-1:0] tf_wp_q, tf_wp_d, tf_rp_q, tf_rp_d, tf_wr;
  logic [TC_W-1:0] tf_cnt_q, tf_cnt_d, tf_free, tf_npush;
  logic            tf_pop;

  // Up to two pushes per cycle; AW always claims a slot before AR.
  always_comb begin
    tf_mem_d = tf_mem_q;
    err_tr   = '0;
    tf_wr    = tf_wp_q;
    tf_npush = '0;
    tf_free  = TC_W'(TRACE_DEPTH) - tf_cnt_q;
    tf_pop   = (tf_cnt_q != '0) && trace_ready;
    if (aw_hs) begin
      if (tf_free != '0) begin
        tf_mem_d[tf_wr] = {2'b00, awlen, awaddr};
        tf_wr           = tf_wr + TP_W'(1);
        tf_npush        = tf_npush + TC_W'(1);
      end else begin
        err_tr[7] = 1'b1;
      end
    end
    if (ar_hs) begin
      if (tf_free > tf_npush) begin
        tf_mem_d[tf_wr] = {2'b01, arlen, araddr};
        tf_wr           = tf_wr + TP_W'(1);
        tf_npush        = tf_npush + TC_W'(1);
      end else begin
        err_tr[7] = 1'b1;
      end
    end
    tf_wp_d  = tf_wr;
    tf_rp_d  = tf_pop ? tf_rp_q + TP_W'(1) : tf_rp_q;
    tf_cnt_d = tf_cnt_q + tf_npush - TC_W'(tf_pop);
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      tf_wp_q  <= '0;
      tf_rp_q  <= '0;
      tf_cnt_q <= '0;
    end else begin
      tf_wp_q  <= tf_wp_d;
      tf_rp_q  <= tf_rp_d;
      tf_cnt_q <= tf_cnt_d;
    end
  end

  always_ff @(posedge ACLK) begin
    tf_mem_q <= tf_mem_d;
  end

  assign trace_valid = (tf_cnt_q != '0);
  assign trace_data  = trace_valid ? tf_mem_q[tf_rp_q] : '0;
`else
  logic trace_unused;
  assign trace_unused = ^{trace_ready, awaddr, araddr};
  assign err_tr       = '0;
  assign trace_valid  = 1'b0;
  assign trace_data   = '0;
`endif

  always_comb begin
    err_d = (err_clear ? 9'd0 : err_q) | err_rd | err_wr | err_wd | err_tr;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      rq_wp_q  <= '0;
      rq_rp_q  <= '0;
      rq_cnt_q <= '0;
      rbeat_q  <= '0;
      rd_cnt_q <= '0;
      wq_wp_q  <= '0;
      wq_rp_q  <= '0;
      wq_cnt_q <= '0;
      wbeat_q  <= '0;
      wr_out_q <= '0;
      wr_cnt_q <= '0;
      wd_q     <= '0;
      err_q    <= '0;
    end else begin
      rq_wp_q  <= rq_wp_d;
      rq_rp_q  <= rq_rp_d;
      rq_cnt_q <= rq_cnt_d;
      rbeat_q  <= rbeat_d;
      rd_cnt_q <= rd_cnt_d;
      wq_wp_q  <= wq_wp_d;
      wq_rp_q  <= wq_rp_d;
      wq_cnt_q <= wq_cnt_d;
      wbeat_q  <= wbeat_d;
      wr_out_q <= wr_out_d;
      wr_cnt_q <= wr_cnt_d;
      wd_q     <= wd_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge ACLK) begin
    rq_mem_q <= rq_mem_d;
    wq_mem_q <= wq_mem_d;
  end

  assign err_status     = err_q;
  assign err_any        = |err_q;
  assign rd_count       = rd_cnt_q;
  assign wr_count       = wr_cnt_q;
  assign rd_outstanding = rq_cnt_q;
  assign wr_outstanding = wr_out_q;

endmodule

// File: doc/axi_protocol_monitor.md
# axi_protocol_monitor

Synthesizable, parametrised AXI4 passive monitor: snoops one master-side port of the interconnect (e.g. an ALU master's S0x port), checks burst-length/LAST, ordering and response rules, counts completed transactions, runs a stall watchdog and optionally logs AW/AR handshakes into a trace FIFO. It drives nothing on the bus and replaces ad-hoc hierarchical `$display` tracing in system benches with reusable, checkable hardware.

## Interface
- ADDR_WIDTH, 32, address width of snooped AW/AR.
- OUTSTANDING_DEPTH, 4, entries per length queue (read and write); power of two.
- TIMEOUT_CYCLES, 1024, stall limit; 0 disables the watchdog.
- TRACE_DEPTH, 16, trace FIFO entries; power of two.

- ACLK  in  1  clock, all logic rising-edge.
- ARESETN  in  1  synchronous, active-low reset.
- awvalid, awready, wvalid, wready, wlast, bvalid, bready, arvalid, arready, rvalid, rready, rlast  in  1 each  snooped handshake signals.
- awaddr, araddr  in  ADDR_WIDTH  snooped addresses.
- awlen, arlen  in  8  snooped burst lengths.
- err_clear  in  1  clears err_status.
- err_status  out  9  sticky error bits (below).
- err_any  out  1  OR of err_status.
- rd_count, wr_count  out  32  completed reads (RLAST beats) / writes (B handshakes), wrapping.
- rd_outstanding, wr_outstanding  out  $clog2(OUTSTANDING_DEPTH)+1  accepted-not-completed bursts.
- trace_valid  out  1; trace_data  out  ADDR_WIDTH+10  {kind[1:0], len[7:0], addr}; trace_ready  in  1.

## Operation
- Handshake = valid && ready sampled at ACLK rise.
- AR HS: push arlen into read length queue; rd_outstanding+1. Queue full: entry dropped, set bit 8.
- R HS: beat counter increments. Queue empty: set bit 2, no other effect. rlast with beats < len+1: bit 0; beat len+1 without rlast: bit 1. On rlast or beat len+1: pop queue, clear counter, rd_outstanding-1; rd_count+1 only on rlast.
- AW HS: push awlen into write length queue (full: drop, bit 8); wr_outstanding+1.
- W HS: write queue empty (no unmatched AW): bit 4, beat ignored. Same LAST check as R against head entry; mismatch either way sets bit 3. Burst end pops write queue only; wr_outstanding waits for B.
- B HS: wr_outstanding 0: bit 5; else wr_outstanding-1, wr_count+1.
- Bit 6 TIMEOUT: watchdog counts cycles with rd_outstanding+wr_outstanding > 0 and no handshake on any channel; sets at TIMEOUT_CYCLES; counter saturates; any handshake or zero outstanding clears it.
- Bit 7 TRACE_OVERFLOW: trace push dropped because FIFO full.
- Same-cycle push and pop on a queue/counter: both applied, net unchanged; AR and R completion same cycle on empty queue counts as unexpected R (push visible next cycle).
- err_clear zeros err_status; an error detected in the same cycle wins (bit set).

## Timing
- All outputs registered; reset values all zero (trace_valid 0, trace_data 0).
- Error bits, counters and outstanding values update one cycle after the causing handshake.
- Trace entry visible (trace_valid) one cycle after handshake; pop on trace_valid && trace_ready, next entry visible next cycle (show-ahead FIFO).
- AW and AR HS same cycle: both pushed, AW entry first; if one slot free, AW kept, AR dropped, bit 7 set.
- ARESETN low mid-burst: queues, counters, FIFO, watchdog cleared next edge; bus activity during reset ignored.
- Timeout latency: bit 6 set exactly TIMEOUT_CYCLES+1 edges after the last handshake.

## Configuration
- AXI_MON_TRACE_EN defined: trace FIFO, kinds 2'b00 = AW, 2'b01 = AR, bit 7 active.
- Undefined: no FIFO storage; trace_valid and trace_data tied 0, trace_ready ignored, bit 7 never sets. All checking and counting unchanged.

## Test plan
- AR addr 0x4000_0010 len 3, four R beats rlast on 4th -> rd_count 1, rd_outstanding 0, err_status 0; trace {01, 0x03, 0x4000_0010}.
- AR len 3, rlast on beat 2 -> err_status 0x001 next cycle; err_clear -> 0x000.
- AW len 0, one W with wlast, B -> wr_count 1; then extra B -> bit 5 (0x020); W with no AW -> bit 4.
- TIMEOUT_CYCLES 8: AR accepted, no R for 20 cycles -> bit 6 set exactly 9 edges after AR HS; TIMEOUT_CYCLES 0 -> never.
- OUTSTANDING_DEPTH 4: 5 back-to-back ARs, no R -> bit 8, rd_outstanding 4; trace_ready 0 with TRACE_DEPTH 4 -> bit 7 after 5th entry (macro defined), never set (undefined).
- Same-cycle AW+AR -> two trace entries, AW first; reset mid-burst -> all outputs 0, next clean burst error-free.
